gate_truth_checker: RTL
=======================

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: cycles each input vector is held before y is sampled.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to run a check; honoured only in IDLE.
REQ-005 SHALL have port tt, input, 4 bits: expected truth table, bit index {a,b} (NAND = 4'b0111); captured on an accepted start.
REQ-006 SHALL have port a, output, 1 bit: stimulus to the gate under test, input a.
REQ-007 SHALL have port b, output, 1 bit: stimulus to the gate under test, input b.
REQ-008 SHALL have port y, input, 1 bit: response of the gate under test; same clock domain, no synchroniser.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when all four vectors are checked.
REQ-011 SHALL have port pass, output, 1 bit: high when the last completed run had no mismatches.
REQ-012 SHALL have port fail_vec, output, 4 bits: bit k set if vector k mismatched in the last run.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-014 In IDLE with start=1, the FSM SHALL latch tt, clear fail_vec and pass, set idx=0, and go to APPLY.
REQ-015 In APPLY, {a,b} SHALL equal idx; the FSM SHALL stay SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-016 In SAMPLE, {a,b} SHALL still equal idx; on the exiting edge fail_vec[idx] SHALL be set to (y != tt_latched[idx]).
REQ-017 From SAMPLE, idx<3 SHALL increment idx and return to APPLY; idx=3 SHALL go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle and pass SHALL be set to (fail_vec==0); the FSM then returns to IDLE.
REQ-019 Each vector SHALL take SETTLE_CYCLES+1 cycles; done SHALL assert 4*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
REQ-020 busy SHALL be 1 in APPLY and SAMPLE, and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored outside IDLE; a tt change mid-run SHALL have no effect.
REQ-022 start asserted in the same cycle done is high SHALL be ignored; a new run needs start while in IDLE.
REQ-023 pass and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-024 In IDLE and DONE, a and b SHALL be 0.
REQ-025 idx SHALL be 2 bits; the settle counter SHALL be 4 bits and reload on every APPLY entry, with no wrap-around beyond idx=3.

Reset
REQ-026 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-027 rst=1 SHALL force a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, idx=0, settle count 0, tt_latched=0.
REQ-028 rst asserted mid-run SHALL abort the run with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-029 Package gate_check_pkg SHALL hold the state enum and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
REQ-030 The settle counter SHALL be a sub-module settle_timer (load, count, expire output); everything else stays in one module.

Verification
REQ-031 Scenario: SETTLE_CYCLES=1, real NAND on a/b->y, tt=TT_NAND, start pulse -> a/b steps 00,01,10,11 at 2 cycles each; done at cycle 9; pass=1; fail_vec=0000.
REQ-032 Scenario: y tied to 1, tt=TT_NAND -> done at cycle 9; pass=0; fail_vec=1000.
REQ-033 Scenario: real NAND, tt=TT_XOR -> fail_vec=0001; pass=0.
REQ-034 Scenario: SETTLE_CYCLES=3, real NAND -> each vector held 4 cycles; done at cycle 17; pass=1.
REQ-035 Scenario: start re-pulsed at cycle 4, tt changed at cycle 5 -> no restart; results match the original tt; one done pulse.
REQ-036 Scenario: rst pulsed at cycle 5 mid-run -> a=b=busy=pass=0 and fail_vec=0 immediately; no done; a fresh start then gives a normal result.

Source files
------------

// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared types and constants for the gate truth-table checker.
//   state_t     : checker FSM state encoding
//   TT_*        : expected truth tables, bit index {a,b}
//   mark_vec()  : returns a fail vector with bit idx set when miss is high
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int SETTLE_W = 4;

    function automatic logic [3:0] mark_vec(input logic [3:0] vec,
                                            input logic [1:0] idx,
                                            input logic       miss);
        logic [3:0] bit_mask;
        bit_mask = 4'b0001 << idx;
        return miss ? (vec | bit_mask) : vec;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Down-counter that times how long a stimulus vector is held before sampling.
//   clk    : clock
//   rst    : asynchronous active-high reset, clears the count
//   load   : reload the count with LOAD_VALUE (wins over count)
//   count  : decrement while nonzero
//   expire : high during the last counted cycle (count active, value 1)
module settle_timer
    import gate_check_pkg::*;
#(
    parameter logic [SETTLE_W-1:0] LOAD_VALUE = 4'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VALUE;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count of 1 means the current cycle is the last one held.
    assign expire = count && (cnt == 4'd1);

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Drives the four {a,b} input combinations into an external 2-input gate,
// holds each for SETTLE_CYCLES cycles, samples y one cycle later and compares
// it against a latched expected truth table.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : one-cycle run request, honoured only in IDLE
//   tt       : expected truth table, bit index {a,b}, captured on accepted start
//   a, b     : stimulus to the gate under test
//   y        : response of the gate under test (same clock domain)
//   busy     : high while vectors are being applied/sampled
//   done     : one-cycle pulse at the end of a run
//   pass     : last completed run had no mismatches
//   fail_vec : bit k set if vector k mismatched in the last run
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start; results of the last run are held
// ST_APPLY  | {a,b}=idx driven, settle timer running
// ST_SAMPLE | {a,b}=idx still driven, y compared on the exit edge
// ST_DONE   | done pulse, pass valid, back to IDLE next cycle
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] tt,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] tt_latched;
    logic       timer_load;
    logic       timer_count;
    logic       timer_expire;
    logic       miss;
    logic [3:0] fail_next;
    logic [1:0] idx_next;

    // The timer reloads on every edge that enters APPLY.
    assign timer_load  = ((state == ST_IDLE) && start) ||
                         ((state == ST_SAMPLE) && (idx != 2'd3));
    assign timer_count = (state == ST_APPLY);

    assign miss      = (y != tt_latched[idx]);
    assign fail_next = mark_vec(fail_vec, idx, miss);
    assign idx_next  = idx + 2'd1;

    settle_timer #(
        .LOAD_VALUE (SETTLE_LOAD)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .count  (timer_count),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            tt_latched <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tt_latched <= tt;
                        fail_vec   <= 4'd0;
                        pass       <= 1'b0;
                        idx        <= 2'd0;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (timer_expire) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    fail_vec <= fail_next;
                    if (idx == 2'd3) begin
                        // pass uses fail_next so it is valid together with done.
                        pass  <= (fail_next == 4'd0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        idx    <= idx_next;
                        {a, b} <= idx_next;
                        state  <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
